array_command_sequencer: RTL and testbench
==========================================

Name: array_command_sequencer

Overview:
- Upstream control stage for the grid of message_passer cells. Buffers host instructions {opcode, repeat} in a small FIFO and broadcasts each opcode to all cells on a shared command bus.
- Runs the cells' ack/ready handshake: a one-cycle ack-low issue, then waits until every cell's ready is high.
- Repeats each opcode repeat+1 times, so a multi-step shift needs a single instruction.

Parameters:
- NUM_PE, 16, number of message_passer cells driven; width of the pe_ready bus.
- FIFO_DEPTH, 8, instruction FIFO entries; power of two, >=2.
- REPEAT_W, 8, width of the repeat field.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- instr_valid  in  1  host instruction valid.
- instr_ready  out  1  FIFO not full; a push occurs when instr_valid && instr_ready.
- instr_data  in  3+REPEAT_W  {opcode[2:0], repeat[REPEAT_W-1:0]}.
- pe_command  out  3  broadcast command_to_execute.
- pe_ack  out  1  broadcast ack; 1 = hold/clear, 0 = execute.
- pe_ready  in  NUM_PE  per-cell ready.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- done  out  1  one-cycle pulse when an instruction's final repetition completes.
- issue_count  out  16  total issues since reset; wraps at 2^16.
- error  out  1  watchdog tripped (present only with the macro).

Behaviour:
- Reset values while reset is low: FIFO empty, pe_ack=1, pe_command=3'b000, busy=0, done=0, issue_count=0, rep_cnt=0, state=IDLE, error=0.
- Reset mid-operation aborts immediately and discards buffered instructions.
- FIFO behaviour:
  - instr_ready = !full.
  - Push and pop in the same cycle are both allowed.
  - When full, instr_ready=0 and instr_valid is ignored. No overflow state exists.
  - A word pushed at edge N is visible as non-empty in cycle N+1.
- IDLE:
  - pe_ack=1.
  - If FIFO non-empty: pop, latch opcode into pe_command and repeat into rep_cnt, go to ISSUE.
- ISSUE (exactly one cycle):
  - pe_ack=0, pe_command stable.
  - issue_count increments.
  - Go to WAIT.
- WAIT:
  - pe_ack=1; pe_command is held.
  - Each cycle, test &pe_ready.
  - If all high and rep_cnt != 0: decrement rep_cnt, go to ISSUE.
  - If all high and rep_cnt == 0: pulse done for one cycle, go to IDLE.
  - Cells drop ready on the edge after ack returns high, so no stale-ready pass can occur. Any partial ready set keeps the FSM waiting.
- Multiply (000) has unbounded cell latency; WAIT has no limit unless the macro is enabled.
- Latency:
  - Push to first pe_ack=0: 2 cycles from an empty FIFO.
  - Back-to-back issue gap for single-cycle ops: 2 cycles (ISSUE, WAIT).
  - An instruction with repeat=r produces r+1 ack-low pulses.
- Boundary cases:
  - repeat at its maximum value gives 2^REPEAT_W issues.
  - The IDLE pop and a push on the same edge with FIFO_DEPTH-1 entries are both accepted.
  - NUM_PE=1 is legal.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter resets on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES before &pe_ready, the FSM enters ERROR: error=1 sticky, pe_ack=1, no further pops.
  - Only reset exits ERROR.
  - instr_ready keeps following FIFO fullness.
- Undefined: no counter, no error port, no ERROR state; WAIT can wait indefinitely.

Decomposition:
- Shared package seq_pkg holds:
  - Opcode localparams: CMD_MULTIPLY=000, CMD_SHIFT_UP=001, CMD_SHIFT_DOWN=010, CMD_SHIFT_LEFT=011, CMD_SHIFT_RIGHT=100, CMD_LOAD_AB=101, CMD_LOAD_S=110, CMD_RESET=111.
  - FSM state encodings: IDLE, ISSUE, WAIT, ERROR.
- One sub-module, seq_cmd_fifo: synchronous FIFO with push/pop/full/empty, parameterised by width and depth, same CLK and async active-low reset.

Test Plan:
- Push {011, repeat=0}; cell model returns ready 1 cycle after ack low → exactly one ack-low pulse with pe_command=011, done pulses once, issue_count=1.
- Push {001, repeat=3} → 4 ack-low pulses with pe_command=001, done only after the 4th all-ready, issue_count=4.
- NUM_PE=16; cell 7 raises ready 20 cycles later than the others → FSM stays in WAIT until cell 7 is high; no extra issue occurs.
- Fill FIFO with 8 instructions while the model stalls ready → instr_ready=0 after the 8th, a 9th push is ignored, all 8 execute in order once ready resumes.
- Assert reset low during WAIT of a {000, repeat=2} with 3 entries queued → outputs return to reset values immediately; after release, busy=0 and nothing is issued.
- With SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=16, ready never rises → error=1 after 16 WAIT cycles, pe_ack stays 1, queued instructions are not popped.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcodes and FSM encodings for the array command sequencer.
package seq_pkg;

  localparam logic [2:0] CMD_MULTIPLY    = 3'b000;
  localparam logic [2:0] CMD_SHIFT_UP    = 3'b001;
  localparam logic [2:0] CMD_SHIFT_DOWN  = 3'b010;
  localparam logic [2:0] CMD_SHIFT_LEFT  = 3'b011;
  localparam logic [2:0] CMD_SHIFT_RIGHT = 3'b100;
  localparam logic [2:0] CMD_LOAD_AB     = 3'b101;
  localparam logic [2:0] CMD_LOAD_S      = 3'b110;
  localparam logic [2:0] CMD_RESET       = 3'b111;

  localparam int ISSUE_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } seq_state_e;

endpackage

// File: rtl/array_command_sequencer_if.sv
// Host instruction port and cell command bus of the array command sequencer.
// The error signal exists only when SEQ_WATCHDOG_EN is defined.
interface array_command_sequencer_if #(
  parameter int NUM_PE   = 16,
  parameter int REPEAT_W = 8
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [REPEAT_W+2:0]   instr_data;
  logic [2:0]            pe_command;
  logic                  pe_ack;
  logic [NUM_PE-1:0]     pe_ready;
  logic                  busy;
  logic                  done;
  logic [15:0]           issue_count;
`ifdef SEQ_WATCHDOG_EN
  logic                  error;
`endif

  modport master (
    output instr_valid, instr_data, pe_ready,
    input  instr_ready, pe_command, pe_ack, busy, done, issue_count
`ifdef SEQ_WATCHDOG_EN
    , input error
`endif
  );

  modport slave (
    input  instr_valid, instr_data, pe_ready,
    output instr_ready, pe_command, pe_ack, busy, done, issue_count
`ifdef SEQ_WATCHDOG_EN
    , output error
`endif
  );
endinterface

// File: rtl/seq_cmd_fifo.sv
// Show-ahead synchronous FIFO holding host instructions; simultaneous push and pop allowed.
module seq_cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == (AW+1)'(0));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage array carries no reset; the pointers alone define valid contents.
  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/array_command_sequencer.sv
// Broadcasts buffered opcodes to the cell array and runs the ack/ready handshake,
// repeating each opcode repeat+1 times. SEQ_WATCHDOG_EN adds a WAIT timeout and error flag.
module array_command_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_PE     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int REPEAT_W   = 8
`ifdef SEQ_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                       CLK,
  input  logic                       reset,
  array_command_sequencer_if.slave   bus
);
  localparam int DW = 3 + REPEAT_W;

  logic [DW-1:0]          w_rdata;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [NUM_PE-1:0]      w_ready;
  logic                   w_all_ready;

  seq_state_e             r_state;
  logic [2:0]             r_cmd;
  logic [REPEAT_W-1:0]    r_rep;
  logic                   r_ack;
  logic                   r_done;
  logic [ISSUE_CNT_W-1:0] r_issue_cnt;
`ifdef SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0]         r_wd_cnt;
  logic                   r_error;
`endif

  assign w_push      = bus.instr_valid && !w_full;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign w_ready     = bus.pe_ready;
  assign w_all_ready = &w_ready;

  assign bus.instr_ready = !w_full;
  assign bus.pe_command  = r_cmd;
  assign bus.pe_ack      = r_ack;
  assign bus.done        = r_done;
  assign bus.issue_count = r_issue_cnt;
  assign bus.busy        = (r_state != ST_IDLE) || !w_empty;
`ifdef SEQ_WATCHDOG_EN
  assign bus.error       = r_error;
`endif

  seq_cmd_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (bus.instr_data),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sequencer FSM; ack, command, done and issue count are all registered here.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= CMD_MULTIPLY;
      r_rep       <= {REPEAT_W{1'b0}};
      r_ack       <= 1'b1;
      r_done      <= 1'b0;
      r_issue_cnt <= {ISSUE_CNT_W{1'b0}};
`ifdef SEQ_WATCHDOG_EN
      r_wd_cnt    <= {WDW{1'b0}};
      r_error     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b1;
          if (!w_empty) begin
            r_cmd       <= w_rdata[DW-1 -: 3];
            r_rep       <= w_rdata[REPEAT_W-1:0];
            r_ack       <= 1'b0;
            r_issue_cnt <= r_issue_cnt + 16'd1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_ack   <= 1'b1;
          r_state <= ST_WAIT;
`ifdef SEQ_WATCHDOG_EN
          r_wd_cnt <= {WDW{1'b0}};
`endif
        end
        ST_WAIT: begin
          r_ack <= 1'b1;
          if (w_all_ready) begin
            if (r_rep != {REPEAT_W{1'b0}}) begin
              r_rep       <= r_rep - REPEAT_W'(1);
              r_ack       <= 1'b0;
              r_issue_cnt <= r_issue_cnt + 16'd1;
              r_state     <= ST_ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
`ifdef SEQ_WATCHDOG_EN
          // Timeout counts WAIT cycles spent without a full ready set.
          else if (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
            r_error <= 1'b1;
            r_state <= ST_ERROR;
          end else begin
            r_wd_cnt <= r_wd_cnt + WDW'(1);
          end
`endif
        end
`ifdef SEQ_WATCHDOG_EN
        ST_ERROR: begin
          r_ack   <= 1'b1;
          r_error <= 1'b1;
          r_state <= ST_ERROR;
        end
`endif
        default: begin
          r_ack   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_array_command_sequencer.sv
// Directed self-checking bench for array_command_sequencer with a per-cell ready model.
module tb_array_command_sequencer;
  import seq_pkg::*;

  localparam int NUM_PE   = 16;
  localparam int REPEAT_W = 8;

  logic CLK;
  logic reset;

  array_command_sequencer_if #(.NUM_PE(NUM_PE), .REPEAT_W(REPEAT_W)) bus ();

  array_command_sequencer #(
    .NUM_PE     (NUM_PE),
    .FIFO_DEPTH (8),
    .REPEAT_W   (REPEAT_W)
`ifdef SEQ_WATCHDOG_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_lows = 0;
  int done_cnt = 0;
  logic [2:0] cmd_log [$];

  int lat [NUM_PE];
  int cnt [NUM_PE];
  bit stall = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cell model: ready drops when ack goes low, then rises lat cycles later unless stalled.
  initial begin
    logic [NUM_PE-1:0] rdy;
    rdy = '1;
    for (int i = 0; i < NUM_PE; i++) begin
      lat[i] = 1;
      cnt[i] = 0;
    end
    bus.pe_ready = rdy;
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < NUM_PE; i++) begin
        if (!bus.pe_ack) begin
          rdy[i] = 1'b0;
          cnt[i] = lat[i];
        end else begin
          if (cnt[i] != 0) cnt[i]--;
          if (cnt[i] == 0 && !stall) rdy[i] = 1'b1;
        end
      end
      bus.pe_ready = rdy;
    end
  end

  // Bus monitor: logs every ack-low cycle and done pulse.
  initial begin
    forever begin
      @(negedge CLK);
      if (reset) begin
        if (!bus.pe_ack) begin
          ack_lows++;
          cmd_log.push_back(bus.pe_command);
        end
        if (bus.done) done_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [2:0] op, input logic [REPEAT_W-1:0] rep);
    @(negedge CLK);
    bus.instr_valid = 1'b1;
    bus.instr_data  = {op, rep};
    @(negedge CLK);
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && bus.busy; i++) @(negedge CLK);
    check_value(tag, 32'(bus.busy), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int a0;
    int d0;
    int b0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    reset = 1'b0;
    repeat (3) @(negedge CLK);

    check_value("rst_ack", 32'(bus.pe_ack), 32'd1);
    check_value("rst_cmd", 32'(bus.pe_command), 32'd0);
    check_value("rst_busy", 32'(bus.busy), 32'd0);
    check_value("rst_done", 32'(bus.done), 32'd0);
    check_value("rst_icnt", 32'(bus.issue_count), 32'd0);
    check_value("rst_irdy", 32'(bus.instr_ready), 32'd1);
`ifdef SEQ_WATCHDOG_EN
    check_value("rst_err", 32'(bus.error), 32'd0);
`endif
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    // Single shift-left, one issue; ack low two cycles after the push edge.
    a0 = ack_lows; d0 = done_cnt; b0 = cmd_log.size();
    push(CMD_SHIFT_LEFT, 8'd0);
    check_value("t1_busy", 32'(bus.busy), 32'd1);
    check_value("t1_ack_hi", 32'(bus.pe_ack), 32'd1);
    @(negedge CLK);
    check_value("t1_ack_lo", 32'(bus.pe_ack), 32'd0);
    check_value("t1_cmd", 32'(bus.pe_command), 32'(CMD_SHIFT_LEFT));
    wait_idle("t1_idle", 100);
    check_value("t1_pulses", 32'(ack_lows - a0), 32'd1);
    check_value("t1_done", 32'(done_cnt - d0), 32'd1);
    check_value("t1_icnt", 32'(bus.issue_count), 32'd1);

    // Shift-up with repeat=3 gives four issues and one done.
    a0 = ack_lows; d0 = done_cnt; b0 = cmd_log.size();
    push(CMD_SHIFT_UP, 8'd3);
    wait_idle("t2_idle", 100);
    check_value("t2_pulses", 32'(ack_lows - a0), 32'd4);
    check_value("t2_done", 32'(done_cnt - d0), 32'd1);
    check_value("t2_icnt", 32'(bus.issue_count), 32'd5);
    for (int k = 0; k < 4 && b0 + k < cmd_log.size(); k++)
      check_value("t2_cmd", 32'(cmd_log[b0 + k]), 32'(CMD_SHIFT_UP));

    // Cell 7 is 20 cycles slower; FSM must keep waiting without re-issuing.
    lat[7] = 21;
    a0 = ack_lows; d0 = done_cnt;
    push(CMD_SHIFT_RIGHT, 8'd0);
    repeat (12) @(negedge CLK);
    check_value("t3_waiting", 32'(bus.busy), 32'd1);
    check_value("t3_ack_hi", 32'(bus.pe_ack), 32'd1);
    check_value("t3_no_done", 32'(done_cnt - d0), 32'd0);
    wait_idle("t3_idle", 100);
    check_value("t3_pulses", 32'(ack_lows - a0), 32'd1);
    check_value("t3_done", 32'(done_cnt - d0), 32'd1);
    lat[7] = 1;

    // Maximum repeat value yields 2^REPEAT_W issues.
    a0 = ack_lows; d0 = done_cnt;
    push(CMD_LOAD_AB, 8'hFF);
    wait_idle("t4_idle", 1200);
    check_value("t4_pulses", 32'(ack_lows - a0), 32'd256);
    check_value("t4_done", 32'(done_cnt - d0), 32'd1);
    check_value("t4_icnt", 32'(bus.issue_count), 32'd262);

    // Stall one instruction in WAIT, fill the FIFO, drop a ninth push, then drain in order.
    stall = 1'b1;
    a0 = ack_lows; d0 = done_cnt; b0 = cmd_log.size();
    push(CMD_LOAD_S, 8'd0);
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      check_value("t5_irdy_open", 32'(bus.instr_ready), 32'd1);
      push(iv[2:0], 8'd0);
    end
    check_value("t5_full", 32'(bus.instr_ready), 32'd0);
    push(CMD_RESET, 8'd5);
    check_value("t5_still_full", 32'(bus.instr_ready), 32'd0);
    check_value("t5_stalled", 32'(ack_lows - a0), 32'd1);
    stall = 1'b0;
    wait_idle("t5_idle", 300);
    check_value("t5_pulses", 32'(ack_lows - a0), 32'd9);
    check_value("t5_done", 32'(done_cnt - d0), 32'd9);
    check_value("t5_icnt", 32'(bus.issue_count), 32'd271);
    if (cmd_log.size() >= b0 + 9) begin
      check_value("t5_cmd_first", 32'(cmd_log[b0]), 32'(CMD_LOAD_S));
      for (int k = 0; k < 8; k++)
        check_value("t5_cmd_order", 32'(cmd_log[b0 + 1 + k]), 32'(k));
    end

    // Reset during WAIT of a multiply with three queued entries.
    stall = 1'b1;
    push(CMD_MULTIPLY, 8'd2);
    repeat (4) @(negedge CLK);
    push(CMD_SHIFT_UP, 8'd0);
    push(CMD_SHIFT_DOWN, 8'd0);
    push(CMD_SHIFT_RIGHT, 8'd0);
    reset = 1'b0;
    #1;
    check_value("t6_ack", 32'(bus.pe_ack), 32'd1);
    check_value("t6_cmd", 32'(bus.pe_command), 32'd0);
    check_value("t6_busy", 32'(bus.busy), 32'd0);
    check_value("t6_icnt", 32'(bus.issue_count), 32'd0);
    check_value("t6_irdy", 32'(bus.instr_ready), 32'd1);
    @(negedge CLK);
    reset = 1'b1;
    stall = 1'b0;
    a0 = ack_lows;
    repeat (20) @(negedge CLK);
    check_value("t6_no_issue", 32'(ack_lows - a0), 32'd0);
    check_value("t6_idle", 32'(bus.busy), 32'd0);
    check_value("t6_icnt_after", 32'(bus.issue_count), 32'd0);

`ifdef SEQ_WATCHDOG_EN
    // Watchdog trips when ready never rises; queued work stays queued.
    stall = 1'b1;
    a0 = ack_lows;
    push(CMD_SHIFT_DOWN, 8'd0);
    push(CMD_LOAD_AB, 8'd0);
    repeat (30) @(negedge CLK);
    check_value("t7_error", 32'(bus.error), 32'd1);
    check_value("t7_ack", 32'(bus.pe_ack), 32'd1);
    check_value("t7_busy", 32'(bus.busy), 32'd1);
    check_value("t7_pulses", 32'(ack_lows - a0), 32'd1);
    stall = 1'b0;
    repeat (10) @(negedge CLK);
    check_value("t7_no_pop", 32'(ack_lows - a0), 32'd1);
    check_value("t7_sticky", 32'(bus.error), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
